// File: rtl/jtopll_wrq_pkg.sv
// Shared constants for the jtopll/jtopl write queue: YM2413 bus recovery times,
// the queued entry layout and the replay FSM state encodings.
package jtopll_wrq_pkg;

  localparam int JTOPLL_ADDR_WAIT = 12;
  localparam int JTOPLL_DATA_WAIT = 84;

  // Wide enough for any recovery time up to 127 cen ticks
  localparam int WAIT_W = 7;

  typedef struct packed {
    logic       addr;
    logic [7:0] din;
  } wrq_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } wrq_state_t;

endpackage

// File: rtl/jtopll_wrq_fifo.sv
// Synchronous FIFO of {addr,din} entries. Only the pointers and the occupancy
// count are reset; the storage array comes up undefined.
module jtopll_wrq_fifo
  import jtopll_wrq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  wrq_entry_t  wdata,
  output wrq_entry_t  rdata,
  output logic [AW:0] level,
  output logic        full,
  output logic        empty
);

  wrq_entry_t          mem [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic                wr_en;
  logic                rd_en;

  // full is judged on the registered level, so a same-cycle pop never frees a slot
  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign rdata = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  // NOTE: the storage array has no reset; entries are only ever read after being written.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/jtopll_wrq.sv
// CPU write queue in front of the OPLL MMR: replays queued writes one at a time,
// holding off ADDR_WAIT/DATA_WAIT cen ticks after each. Optional: JTOPLL_WRQ_OVF_EN.
module jtopll_wrq
  import jtopll_wrq_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int AW        = 3,
  parameter int ADDR_WAIT = JTOPLL_ADDR_WAIT,
  parameter int DATA_WAIT = JTOPLL_DATA_WAIT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic [7:0]  cpu_din,
  input  logic        cpu_addr,
  input  logic        cpu_wr,
  output logic        cpu_full,
  output logic [AW:0] level,
  output logic        ovf,
  input  logic        ovf_clr,
  output logic [7:0]  din,
  output logic        addr,
  output logic        write
);

  wrq_state_t        state, state_nx;
  logic [WAIT_W-1:0] cnt, cnt_nx;
  logic [7:0]        din_nx;
  logic              addr_nx;
  logic              write_nx;
  logic              pop;
  logic              empty;
  wrq_entry_t        wr_entry;
  wrq_entry_t        head;

  assign wr_entry = '{addr: cpu_addr, din: cpu_din};

  jtopll_wrq_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cpu_wr),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (head),
    .level (level),
    .full  (cpu_full),
    .empty (empty)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    din_nx   = din;
    addr_nx  = addr;
    write_nx = 1'b0;
    pop      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          din_nx   = head.din;
          addr_nx  = head.addr;
          write_nx = 1'b1;
          state_nx = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_nx   = addr ? WAIT_W'(DATA_WAIT) : WAIT_W'(ADDR_WAIT);
        state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        // Leave on the same edge the count hits zero so pulses are 2 clk + WAIT ticks apart
        if (cnt == '0) begin
          state_nx = ST_IDLE;
        end else if (cen) begin
          cnt_nx = cnt - WAIT_W'(1);
          if (cnt == WAIT_W'(1)) state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      din   <= '0;
      addr  <= 1'b0;
      write <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      din   <= din_nx;
      addr  <= addr_nx;
      write <= write_nx;
    end
  end

`ifdef JTOPLL_WRQ_OVF_EN
  // Set has priority over clear so an overflow is never lost
  always_ff @(posedge clk) begin
    if (rst)                      ovf <= 1'b0;
    else if (cpu_wr && cpu_full)  ovf <= 1'b1;
    else if (ovf_clr)             ovf <= 1'b0;
  end
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  assign ovf            = 1'b0;
`endif

endmodule

// File: tb/tb_jtopll_wrq.sv
// Scoreboard bench for jtopll_wrq: stimulus pushes expected MMR writes into a
// queue, a monitor pops and compares on every write pulse.
module tb_jtopll_wrq;
  import jtopll_wrq_pkg::*;

  localparam int DEPTH = 8;
  localparam int AW    = 3;
`ifdef JTOPLL_WRQ_OVF_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cen = 1'b0;
  logic [7:0]    cpu_din = '0;
  logic          cpu_addr = 1'b0;
  logic          cpu_wr = 1'b0;
  logic          cpu_full;
  logic [AW:0]   level;
  logic          ovf;
  logic          ovf_clr = 1'b0;
  logic [7:0]    din;
  logic          addr;
  logic          write;

  int            tests = 0;
  int            fails = 0;
  int            cyc = 0;
  int            cen_mode = 0;   // 0: held low, 1: every clk, 4: every 4th clk
  int            cen_div = 0;
  logic [8:0]    exp_q[$];
  int            pulse_cyc[$];
  logic          prev_write = 1'b0;

  jtopll_wrq #(
    .DEPTH     (DEPTH),
    .AW        (AW),
    .ADDR_WAIT (JTOPLL_ADDR_WAIT),
    .DATA_WAIT (JTOPLL_DATA_WAIT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cen      (cen),
    .cpu_din  (cpu_din),
    .cpu_addr (cpu_addr),
    .cpu_wr   (cpu_wr),
    .cpu_full (cpu_full),
    .level    (level),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr),
    .din      (din),
    .addr     (addr),
    .write    (write)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // cen changes on the falling edge, so a mode change made after edge K applies from edge K+1
  always @(negedge clk) begin
    cen_div++;
    cen = (cen_mode == 1) || (cen_mode == 4 && (cen_div % 4) == 0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write pulse must match the oldest outstanding expected entry
  always @(posedge clk) begin
    logic [8:0] e;
    #1;
    if (write === 1'b1) begin
      check("write_one_clk", prev_write, 1'b0);
      pulse_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got %h expected no write (cycle %0d)", {addr, din}, cyc);
      end else begin
        e = exp_q.pop_front();
        check("write_entry", {addr, din}, e);
      end
    end
    prev_write = write;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic a, input logic [7:0] d, input logic accepted);
    cpu_addr = a;
    cpu_din  = d;
    cpu_wr   = 1'b1;
    if (accepted) exp_q.push_back({a, d});
    tick(1);
    cpu_wr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap;
    int n;

    // Reset state
    tick(3);
    check("rst_level", level, 0);
    check("rst_full", cpu_full, 0);
    check("rst_write", write, 0);
    check("rst_din", din, 0);
    check("rst_addr", addr, 0);
    check("rst_ovf", ovf, 0);
    rst = 1'b0;

    // 1: single address write, 2 clk latency; spacing with cen every 4th clk.
    // 12 ticks at period 4 span 45..48 clk depending on phase, plus 2 clk -> 47..50.
    cen_mode = 4;
    wr(1'b0, 8'h10, 1'b1);
    check("t1_level_after_push", level, 1);
    check("t1_write_not_yet", write, 0);
    tick(1);
    check("t1_write_pulse", write, 1);
    check("t1_din", din, 8'h10);
    check("t1_addr", addr, 0);
    check("t1_level_after_pop", level, 0);
    wr(1'b0, 8'h20, 1'b1);
    tick(110);
    check("t1_pulse_count", pulse_cyc.size(), 2);
    if (pulse_cyc.size() >= 2) begin
      gap = pulse_cyc[1] - pulse_cyc[0];
      check("t1_gap_range", (gap >= 47 && gap <= 50), 1);
    end

    // 2: cen every clk; addr gap 2+12, data gap 2+84
    cen_mode = 1;
    n = pulse_cyc.size();
    wr(1'b0, 8'h30, 1'b1);
    wr(1'b1, 8'h1F, 1'b1);
    wr(1'b0, 8'h40, 1'b1);
    tick(130);
    check("t2_pulse_count", pulse_cyc.size(), n + 3);
    if (pulse_cyc.size() >= n + 3) begin
      check("t2_gap_addr", pulse_cyc[n+1] - pulse_cyc[n], 14);
      check("t2_gap_data", pulse_cyc[n+2] - pulse_cyc[n+1], 86);
    end
    check("t2_level_drained", level, 0);

    // 3 + 6: stall in WAIT with cen low, burst 10 writes into DEPTH=8
    cen_mode = 0;
    wr(1'b1, 8'hAA, 1'b1);
    tick(3);
    n = pulse_cyc.size();
    for (int i = 0; i < 10; i++) wr(1'b0, 8'hB0 + 8'(i), i < DEPTH);
    check("t3_level_full", level, DEPTH);
    check("t3_cpu_full", cpu_full, 1);
    check("t3_ovf_set", ovf, OVF_EN);
    check("t3_no_pulse_in_burst", pulse_cyc.size(), n);
    tick(50);
    check("t6_frozen_no_pulse", pulse_cyc.size(), n);
    check("t6_frozen_level", level, DEPTH);
    cpu_din  = 8'hFF;
    cpu_wr   = 1'b1;
    ovf_clr  = 1'b1;
    tick(1);
    cpu_wr   = 1'b0;
    check("t3_ovf_set_wins", ovf, OVF_EN);
    check("t3_dropped_level", level, DEPTH);
    tick(1);
    ovf_clr = 1'b0;
    check("t3_ovf_cleared", ovf, 0);

    // 4: resume cen; the pending 84-tick wait ends at edge +84, IDLE pops at +85
    cen_mode = 1;
    tick(84);
    check("t4_level_before_pop", level, DEPTH);
    check("t4_write_before_pop", write, 0);
    cpu_addr = 1'b0;
    cpu_din  = 8'hEE;
    cpu_wr   = 1'b1;
    tick(1);
    cpu_wr   = 1'b0;
    check("t4_level_8_to_7", level, DEPTH - 1);
    check("t4_write_on_pop", write, 1);
    check("t4_din_head", din, 8'hB0);
    check("t4_full_released", cpu_full, 0);
    check("t4_ovf_on_drop", ovf, OVF_EN);

    // 5: reset while in WAIT with queued entries
    tick(5);
    check("t5_level_before_rst", level, DEPTH - 1);
    rst = 1'b1;
    tick(1);
    check("t5_rst_level", level, 0);
    check("t5_rst_write", write, 0);
    check("t5_rst_full", cpu_full, 0);
    check("t5_rst_din", din, 0);
    check("t5_rst_ovf", ovf, 0);
    rst = 1'b0;
    exp_q.delete();
    n = pulse_cyc.size();
    tick(100);
    check("t5_no_pulse_after_rst", pulse_cyc.size(), n);

    // Queue is usable again after reset
    wr(1'b1, 8'h5A, 1'b1);
    tick(1);
    check("t5_restart_pulse", write, 1);
    tick(3);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
